rv64_fetch_decode_execute: RTL and testbench

Single-cycle RV64I front half: holds the PC, decodes the current instruction, and computes the ALU result and next PC in the same cycle. The core top level instantiates it. The register file, CSR unit, data memory and writeback mux sit outside the block. Its outputs drive the register-file read/write addresses, the memory request, the CSR unit controls and the simulation status.

---
 rtl/rv64_fetch_decode_execute.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_rv64_fetch_decode_execute.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64_fetch_decode_execute.sv
// rv64_fetch_decode_execute: single-cycle RV64I PC, decode and ALU.
// Everything except the PC register is combinational from instr and operands.
module rv64_fetch_decode_execute #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] csr_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_wen,
  output logic [63:0] alu_result,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mem_op,
  output logic        mem_to_reg,
  output logic        is_csr,
  output logic [11:0] csr_addr,
  output logic        ecall,
  output logic        mret,
  output logic        error,
  output logic        done
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMMW  = 7'b0011011;
  localparam logic [6:0] OP_REGW  = 7'b0111011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7z;
  logic        f7s;
  logic        reg_form;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;
  logic [63:0] imm_u;
  logic [63:0] imm_j;
  logic [63:0] pc4;
  logic [63:0] jalr_t;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign f7z      = (f7 == 7'b0000000);
  assign f7s      = (f7 == 7'b0100000);
  assign reg_form = instr[5];

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign pc4    = pc + 64'd4;
  assign jalr_t = (rs1_data + imm_i) & ~64'd1;

  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;

  assign is_ecall  = (instr == 32'h0000_0073);
  assign is_ebreak = (instr == 32'h0010_0073);
  assign is_mret   = (instr == 32'h3020_0073);

  // 64-bit ALU for OP and OP-IMM
  logic [63:0] alu_b;
  logic [5:0]  sh6;
  logic [63:0] sra64;
  logic [63:0] alu64;
  logic        alu64_ok;

  assign alu_b = reg_form ? rs2_data : imm_i;
  assign sh6   = alu_b[5:0];
  assign sra64 = $signed(rs1_data) >>> sh6;

  // 64-bit result select and funct7 legality
  always_comb begin
    alu64    = '0;
    alu64_ok = 1'b1;
    unique case (f3)
      3'b000: begin
        alu64_ok = !reg_form || f7z || f7s;
        alu64    = (reg_form && f7s) ? rs1_data - alu_b
                                     : rs1_data + alu_b;
      end
      3'b001: begin
        alu64_ok = reg_form ? f7z : (instr[31:26] == 6'b0);
        alu64    = rs1_data << sh6;
      end
      3'b010: begin
        alu64_ok = !reg_form || f7z;
        alu64    = {63'b0, $signed(rs1_data) < $signed(alu_b)};
      end
      3'b011: begin
        alu64_ok = !reg_form || f7z;
        alu64    = {63'b0, rs1_data < alu_b};
      end
      3'b100: begin
        alu64_ok = !reg_form || f7z;
        alu64    = rs1_data ^ alu_b;
      end
      3'b101: begin
        alu64_ok = reg_form ? (f7z || f7s)
                 : (instr[31:26] == 6'b000000 ||
                    instr[31:26] == 6'b010000);
        alu64    = instr[30] ? sra64 : rs1_data >> sh6;
      end
      3'b110: begin
        alu64_ok = !reg_form || f7z;
        alu64    = rs1_data | alu_b;
      end
      3'b111: begin
        alu64_ok = !reg_form || f7z;
        alu64    = rs1_data & alu_b;
      end
    endcase
  end

  // 32-bit ALU for OP-32 and OP-IMM-32
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  sh5;
  logic [31:0] sraw;
  logic [31:0] w_res;
  logic        aluw_ok;
  logic [63:0] aluw;

  assign w_a  = rs1_data[31:0];
  assign w_b  = alu_b[31:0];
  assign sh5  = w_b[4:0];
  assign sraw = $signed(w_a) >>> sh5;
  assign aluw = {{32{w_res[31]}}, w_res};

  // word result select; imm[5]=1 on W shifts fails the funct7 check
  always_comb begin
    w_res   = '0;
    aluw_ok = 1'b1;
    unique case (f3)
      3'b000: begin
        aluw_ok = !reg_form || f7z || f7s;
        w_res   = (reg_form && f7s) ? w_a - w_b : w_a + w_b;
      end
      3'b001: begin
        aluw_ok = f7z;
        w_res   = w_a << sh5;
      end
      3'b101: begin
        aluw_ok = f7z || f7s;
        w_res   = instr[30] ? sraw : w_a >> sh5;
      end
      default: aluw_ok = 1'b0;
    endcase
  end

  // branch condition
  logic taken;
  logic br_ok;

  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    unique case (f3)
      3'b000: taken = (rs1_data == rs2_data);
      3'b001: taken = (rs1_data != rs2_data);
      3'b100: taken = $signed(rs1_data) < $signed(rs2_data);
      3'b101: taken = $signed(rs1_data) >= $signed(rs2_data);
      3'b110: taken = rs1_data < rs2_data;
      3'b111: taken = rs1_data >= rs2_data;
      default: br_ok = 1'b0;
    endcase
  end

  logic        ill;
  logic        wen;
  logic        ld;
  logic        st;
  logic        csr;
  logic        jal;
  logic        jalr;
  logic        br;
  logic [63:0] res;

  // main opcode decode
  always_comb begin
    ill  = 1'b0;
    wen  = 1'b0;
    ld   = 1'b0;
    st   = 1'b0;
    csr  = 1'b0;
    jal  = 1'b0;
    jalr = 1'b0;
    br   = 1'b0;
    res  = '0;
    unique case (opcode)
      OP_LUI: begin
        wen = 1'b1;
        res = imm_u;
      end
      OP_AUIPC: begin
        wen = 1'b1;
        res = pc + imm_u;
      end
      OP_JAL: begin
        wen = 1'b1;
        jal = 1'b1;
        res = pc4;
      end
      OP_JALR: begin
        wen  = 1'b1;
        jalr = 1'b1;
        res  = pc4;
        ill  = (f3 != 3'b000);
      end
      OP_BR: begin
        br  = 1'b1;
        ill = !br_ok;
      end
      OP_LD: begin
        wen = 1'b1;
        ld  = 1'b1;
        res = rs1_data + imm_i;
        ill = (f3 == 3'b111);
      end
      OP_ST: begin
        st  = 1'b1;
        res = rs1_data + imm_s;
        ill = f3[2];
      end
      OP_IMM, OP_REG: begin
        wen = 1'b1;
        res = alu64;
        ill = !alu64_ok;
      end
      OP_IMMW, OP_REGW: begin
        wen = 1'b1;
        res = aluw;
        ill = !aluw_ok;
      end
      OP_SYS: begin
        if (f3 == 3'b000) begin
          ill = !(is_ecall || is_ebreak || is_mret);
        end else if (f3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          wen = 1'b1;
          csr = 1'b1;
          res = csr_data;
        end
      end
      default: ill = 1'b1;
    endcase
  end

  // next PC, highest priority first
  logic [63:0] npc;

  always_comb begin
    npc = pc4;
    if (redirect_valid) begin
      npc = redirect_pc;
    end else if (ill || is_ebreak) begin
      npc = pc;
    end else if (jal) begin
      npc = pc + imm_j;
    end else if (jalr) begin
      npc = jalr_t;
    end else if (br && taken) begin
      npc = pc + imm_b;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= npc;
    end
  end

  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign rd         = instr[11:7];
  assign csr_addr   = instr[31:20];
  assign alu_result = res;
  assign mem_op     = f3;
  assign mem_to_reg = ld & ~ill;
  assign is_csr     = csr & ~ill;
  assign ecall      = is_ecall;
  assign mret       = is_mret;
  assign reg_wen    = wen & ~ill & ~rst;
  assign mem_rd     = ld & ~ill & ~rst;
  assign mem_wr     = st & ~ill & ~rst;
  assign error      = ill & ~rst;
  assign done       = is_ebreak & ~rst;

endmodule

// File: tb/tb_rv64_fetch_decode_execute.sv
// tb_rv64_fetch_decode_execute: random + directed scoreboard bench.
// Expected values come from a mnemonic-level reference model.
module tb_rv64_fetch_decode_execute;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] csr_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_wen;
  logic [63:0] alu_result;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_op;
  logic        mem_to_reg;
  logic        is_csr;
  logic [11:0] csr_addr;
  logic        ecall;
  logic        mret;
  logic        error;
  logic        done;

  rv64_fetch_decode_execute #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .csr_data(csr_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pc(pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_wen(reg_wen), .alu_result(alu_result),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_op(mem_op), .mem_to_reg(mem_to_reg),
    .is_csr(is_csr), .csr_addr(csr_addr),
    .ecall(ecall), .mret(mret),
    .error(error), .done(done)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] res;
    logic [63:0] npc;
    logic [26:0] fields;
    logic [2:0]  mop;
    logic        wen;
    logic        mrd;
    logic        mwr;
    logic        m2r;
    logic        csr;
    logic        ecall;
    logic        mret;
    logic        err;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [63:0] mpc = RST_PC;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic string mnem(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    case (op)
      7'h37: return "LUI";
      7'h17: return "AUIPC";
      7'h6f: return "JAL";
      7'h67: if (f3 == 3'd0) return "JALR";
      7'h63:
        case (f3)
          3'd0: return "BEQ";
          3'd1: return "BNE";
          3'd4: return "BLT";
          3'd5: return "BGE";
          3'd6: return "BLTU";
          3'd7: return "BGEU";
          default: ;
        endcase
      7'h03:
        case (f3)
          3'd0: return "LB";
          3'd1: return "LH";
          3'd2: return "LW";
          3'd3: return "LD";
          3'd4: return "LBU";
          3'd5: return "LHU";
          3'd6: return "LWU";
          default: ;
        endcase
      7'h23:
        case (f3)
          3'd0: return "SB";
          3'd1: return "SH";
          3'd2: return "SW";
          3'd3: return "SD";
          default: ;
        endcase
      7'h13:
        case (f3)
          3'd0: return "ADDI";
          3'd2: return "SLTI";
          3'd3: return "SLTIU";
          3'd4: return "XORI";
          3'd6: return "ORI";
          3'd7: return "ANDI";
          3'd1: if (i[31:26] == 6'h00) return "SLLI";
          3'd5: begin
            if (i[31:26] == 6'h00) return "SRLI";
            if (i[31:26] == 6'h10) return "SRAI";
          end
          default: ;
        endcase
      7'h33:
        case ({f7, f3})
          {7'h00, 3'd0}: return "ADD";
          {7'h20, 3'd0}: return "SUB";
          {7'h00, 3'd1}: return "SLL";
          {7'h00, 3'd2}: return "SLT";
          {7'h00, 3'd3}: return "SLTU";
          {7'h00, 3'd4}: return "XOR";
          {7'h00, 3'd5}: return "SRL";
          {7'h20, 3'd5}: return "SRA";
          {7'h00, 3'd6}: return "OR";
          {7'h00, 3'd7}: return "AND";
          default: ;
        endcase
      7'h1b:
        case (f3)
          3'd0: return "ADDIW";
          3'd1: if (f7 == 7'h00) return "SLLIW";
          3'd5: begin
            if (f7 == 7'h00) return "SRLIW";
            if (f7 == 7'h20) return "SRAIW";
          end
          default: ;
        endcase
      7'h3b:
        case ({f7, f3})
          {7'h00, 3'd0}: return "ADDW";
          {7'h20, 3'd0}: return "SUBW";
          {7'h00, 3'd1}: return "SLLW";
          {7'h00, 3'd5}: return "SRLW";
          {7'h20, 3'd5}: return "SRAW";
          default: ;
        endcase
      7'h73: begin
        if (i == 32'h0000_0073) return "ECALL";
        if (i == 32'h0010_0073) return "EBREAK";
        if (i == 32'h3020_0073) return "MRET";
        case (f3)
          3'd1: return "CSRRW";
          3'd2: return "CSRRS";
          3'd3: return "CSRRC";
          3'd5: return "CSRRWI";
          3'd6: return "CSRRSI";
          3'd7: return "CSRRCI";
          default: ;
        endcase
      end
      default: ;
    endcase
    return "ILL";
  endfunction

  function automatic exp_t model(
    input logic [31:0] i, input logic [63:0] p,
    input logic [63:0] a, input logic [63:0] b,
    input logic [63:0] c, input logic rv,
    input logic [63:0] rp, input logic r);
    exp_t e;
    string m;
    logic [63:0] nx, iI, iS, iB, iU, iJ;
    iI = {{52{i[31]}}, i[31:20]};
    iS = {{52{i[31]}}, i[31:25], i[11:7]};
    iB = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    iU = {{32{i[31]}}, i[31:12], 12'b0};
    iJ = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '0;
    e.pc = p;
    e.fields = {i[19:15], i[24:20], i[11:7], i[31:20]};
    e.mop = i[14:12];
    e.wen = 1'b1;
    nx = p + 64'd4;
    m = mnem(i);
    case (m)
      "LUI":   e.res = iU;
      "AUIPC": e.res = p + iU;
      "JAL":  begin e.res = p + 64'd4; nx = p + iJ; end
      "JALR": begin e.res = p + 64'd4; nx = (a + iI) & ~64'd1; end
      "BEQ":  begin e.wen = 0; if (a == b) nx = p + iB; end
      "BNE":  begin e.wen = 0; if (a != b) nx = p + iB; end
      "BLT":  begin e.wen = 0; if ($signed(a) < $signed(b)) nx = p + iB; end
      "BGE":  begin e.wen = 0; if ($signed(a) >= $signed(b)) nx = p + iB; end
      "BLTU": begin e.wen = 0; if (a < b) nx = p + iB; end
      "BGEU": begin e.wen = 0; if (a >= b) nx = p + iB; end
      "LB", "LH", "LW", "LD", "LBU", "LHU", "LWU": begin
        e.mrd = 1; e.m2r = 1; e.res = a + iI;
      end
      "SB", "SH", "SW", "SD": begin
        e.wen = 0; e.mwr = 1; e.res = a + iS;
      end
      "ADDI":  e.res = a + iI;
      "SLTI":  e.res = {63'b0, $signed(a) < $signed(iI)};
      "SLTIU": e.res = {63'b0, a < iI};
      "XORI":  e.res = a ^ iI;
      "ORI":   e.res = a | iI;
      "ANDI":  e.res = a & iI;
      "SLLI":  e.res = a << iI[5:0];
      "SRLI":  e.res = a >> iI[5:0];
      "SRAI":  e.res = $signed(a) >>> iI[5:0];
      "ADD":   e.res = a + b;
      "SUB":   e.res = a - b;
      "SLL":   e.res = a << b[5:0];
      "SLT":   e.res = {63'b0, $signed(a) < $signed(b)};
      "SLTU":  e.res = {63'b0, a < b};
      "XOR":   e.res = a ^ b;
      "SRL":   e.res = a >> b[5:0];
      "SRA":   e.res = $signed(a) >>> b[5:0];
      "OR":    e.res = a | b;
      "AND":   e.res = a & b;
      "ADDIW": e.res = sx32(a[31:0] + iI[31:0]);
      "SLLIW": e.res = sx32(a[31:0] << iI[4:0]);
      "SRLIW": e.res = sx32(a[31:0] >> iI[4:0]);
      "SRAIW": e.res = sx32($signed(a[31:0]) >>> iI[4:0]);
      "ADDW":  e.res = sx32(a[31:0] + b[31:0]);
      "SUBW":  e.res = sx32(a[31:0] - b[31:0]);
      "SLLW":  e.res = sx32(a[31:0] << b[4:0]);
      "SRLW":  e.res = sx32(a[31:0] >> b[4:0]);
      "SRAW":  e.res = sx32($signed(a[31:0]) >>> b[4:0]);
      "ECALL":  begin e.wen = 0; e.ecall = 1; end
      "MRET":   begin e.wen = 0; e.mret = 1; end
      "EBREAK": begin e.wen = 0; e.done = 1; end
      "CSRRW", "CSRRS", "CSRRC",
      "CSRRWI", "CSRRSI", "CSRRCI": begin
        e.csr = 1; e.res = c;
      end
      default: begin e.wen = 0; e.err = 1; end
    endcase
    if (rv) e.npc = rp;
    else if (e.err || e.done) e.npc = p;
    else e.npc = nx;
    if (r) begin
      e.err = 0; e.done = 0; e.wen = 0;
      e.mrd = 0; e.mwr = 0; e.npc = RST_PC;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] i;
    int k;
    i = $urandom();
    k = $urandom_range(0, 12);
    case (k)
      0: i[6:0] = 7'h37;
      1: i[6:0] = 7'h17;
      2: i[6:0] = 7'h6f;
      3: begin i[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) i[14:12] = 3'd0; end
      4: i[6:0] = 7'h63;
      5: i[6:0] = 7'h03;
      6: i[6:0] = 7'h23;
      7, 8: begin
        i[6:0] = (k == 7) ? 7'h13 : 7'h1b;
        if ($urandom_range(0, 1) != 0)
          i[31:26] = $urandom_range(0, 1) != 0 ? 6'h10 : 6'h00;
      end
      9, 10: begin
        i[6:0] = (k == 9) ? 7'h33 : 7'h3b;
        case ($urandom_range(0, 3))
          0, 1: i[31:25] = 7'h00;
          2: i[31:25] = 7'h20;
          default: ;
        endcase
      end
      11: begin
        i[6:0] = 7'h73;
        case ($urandom_range(0, 5))
          0: i = 32'h0000_0073;
          1: i = 32'h0010_0073;
          2: i = 32'h3020_0073;
          default: ;
        endcase
      end
      default: ;
    endcase
    return i;
  endfunction

  task automatic drive(input logic r, input logic [31:0] i,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic rv,
                       input logic [63:0] rp);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    instr = i;
    rs1_data = a;
    rs2_data = b;
    csr_data = c;
    redirect_valid = rv;
    redirect_pc = rp;
    e = model(i, mpc, a, b, c, rv, rp, r);
    q.push_back(e);
    mpc = e.npc;
  endtask

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (pc model %h)",
               n, act, req, mpc);
    end
  endtask

  // monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("pc", pc, m.pc);
        chk("fields", 64'({rs1, rs2, rd, csr_addr}), 64'(m.fields));
        chk("reg_wen", 64'(reg_wen), 64'(m.wen));
        chk("mem_rd", 64'(mem_rd), 64'(m.mrd));
        chk("mem_wr", 64'(mem_wr), 64'(m.mwr));
        chk("mem_to_reg", 64'(mem_to_reg), 64'(m.m2r));
        chk("is_csr", 64'(is_csr), 64'(m.csr));
        chk("ecall", 64'(ecall), 64'(m.ecall));
        chk("mret", 64'(mret), 64'(m.mret));
        chk("error", 64'(error), 64'(m.err));
        chk("done", 64'(done), 64'(m.done));
        if (m.wen || m.mrd || m.mwr)
          chk("alu_result", alu_result, m.res);
        if (m.mrd || m.mwr)
          chk("mem_op", 64'(mem_op), 64'(m.mop));
      end
    end
  end

  // stimulus: directed cases first, then random traffic
  initial begin
    logic [63:0] a;
    logic [63:0] b;
    rst = 1'b1;
    instr = '0;
    rs1_data = '0;
    rs2_data = '0;
    csr_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    drive(1, 32'h0050_0093, 0, 0, 0, 0, 0);
    drive(0, 32'h0050_0093, 0, 0, 0, 0, 0);
    drive(0, 32'h0020_8463, 7, 7, 0, 0, 0);
    drive(0, 32'h0020_8463, 7, 8, 0, 0, 0);
    drive(0, 32'h0002_80e7, 64'h8000_1003, 0, 0, 0, 0);
    drive(0, 32'h0101_3183, 64'h8000_2000, 0, 0, 0, 0);
    drive(0, 32'h0031_00bb, 64'h7fff_ffff, 1, 0, 0, 0);
    drive(0, 32'h0000_0000, 0, 0, 0, 0, 0);
    drive(0, 32'h0000_0000, 0, 0, 0, 1, 64'h8000_0200);
    drive(0, 32'h0000_0073, 0, 0, 0, 1, 64'h8000_0100);
    drive(0, 32'h0010_0073, 0, 0, 0, 0, 0);
    drive(0, 32'h3420_2173, 0, 0, 64'hdead_beef, 0, 0);
    drive(1, 32'h0000_006f, 0, 0, 0, 1, 64'h1234);
    drive(0, 32'h0000_006f, 0, 0, 0, 0, 0);
    drive(0, 32'h0210_101b, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      a = {$urandom(), $urandom()};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 70));
      drive($urandom_range(0, 49) == 0, gen_instr(), a, b,
            {$urandom(), $urandom()}, $urandom_range(0, 7) == 0,
            {$urandom(), $urandom()});
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
